// File: rtl/core_rr_mux.sv
// rtl/core_rr_mux.sv - Round-robin N:1 stream mux with registered output; optional burst lock via CORE_RR_MUX_LOCK_EN
module core_rr_mux #(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_INPUTS-1:0]          i_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
`ifdef CORE_RR_MUX_LOCK_EN
  input  logic [NUM_INPUTS-1:0]          i_last,
`endif
  output logic [NUM_INPUTS-1:0]          o_ready,
  output logic                           o_valid,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]               o_sel,
  input  logic                           i_ready
);

  // The output register may take a new beat when it is empty or being drained.
  logic                  load_en;
  logic [SEL_W-1:0]      rr_ptr;
  logic                  gnt_found;
  logic [SEL_W-1:0]      gnt_idx;
  logic [SEL_W:0]        cand;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [SEL_W-1:0]      ptr_next;
  logic                  xfer;
  logic                  locked;
  logic [SEL_W-1:0]      lock_ch;
  logic                  beat_last;

  assign load_en = !o_valid || i_ready;

  // Grant search: while a burst holds the lock only the owner may be granted,
  // otherwise scan upward from rr_ptr with wrap and take the first requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (locked) begin
      gnt_found = i_valid[lock_ch];
      gnt_idx   = lock_ch;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
        if (cand >= (SEL_W+1)'(NUM_INPUTS)) begin
          cand = cand - (SEL_W+1)'(NUM_INPUTS);
        end
        if (!gnt_found && i_valid[cand[SEL_W-1:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand[SEL_W-1:0];
        end
      end
    end
  end

  // Payload mux for the granted channel; only feeds the output register.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        gnt_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot accept: depends on valids, pointer, lock and i_ready, never on data.
  always_comb begin
    o_ready = '0;
    if (!i_rst && load_en && gnt_found) begin
      o_ready[gnt_idx] = 1'b1;
    end
  end

  assign xfer     = !i_rst && load_en && gnt_found;
  assign ptr_next = (gnt_idx == SEL_W'(NUM_INPUTS-1)) ? '0 : gnt_idx + SEL_W'(1);

`ifdef CORE_RR_MUX_LOCK_EN
  typedef enum logic {ST_OPEN = 1'b0, ST_LOCK = 1'b1} lock_state_t;

  lock_state_t state;
  lock_state_t state_next;

  assign beat_last = i_last[gnt_idx];

  // Lock state register; the owner is captured on the beat that opens a burst.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_OPEN;
      lock_ch <= '0;
    end else begin
      state <= state_next;
      if (xfer && !beat_last) begin
        lock_ch <= gnt_idx;
      end
    end
  end

  // Any accepted beat decides the lock: non-last holds it, last releases it.
  always_comb begin
    state_next = state;
    if (xfer) begin
      state_next = beat_last ? ST_OPEN : ST_LOCK;
    end
  end

  // Lock output decode used by the grant search.
  always_comb begin
    locked = (state == ST_LOCK);
  end
`else
  assign beat_last = 1'b1;
  assign locked    = 1'b0;
  assign lock_ch   = '0;
`endif

  // Output register and round-robin pointer; pointer moves only when a beat
  // is accepted that ends its arbitration unit (always, without locking).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sel   <= '0;
      rr_ptr  <= '0;
    end else if (load_en) begin
      if (xfer) begin
        o_valid <= 1'b1;
        o_data  <= gnt_data;
        o_sel   <= gnt_idx;
        if (beat_last) begin
          rr_ptr <= ptr_next;
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_rr_mux.sv
// tb/tb_core_rr_mux.sv - Directed self-checking bench for core_rr_mux (NUM_INPUTS=4, DATA_WIDTH=64)
module tb_core_rr_mux;

  localparam int DW = 64;
  localparam int N  = 4;

  logic          i_clk;
  logic          i_rst;
  logic [N-1:0]  i_valid;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]  i_last;
  logic [N-1:0]  o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [1:0]    o_sel;
  logic          i_ready;

  int errors;
  int checks;

  core_rr_mux #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
`ifdef CORE_RR_MUX_LOCK_EN
    .i_last  (i_last),
`endif
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .i_ready (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_data_default();
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = 64'h10 + 64'(k);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 4'b1111; i_ready = 1'b1; i_last = '1;
    set_data_default();
    step();
    #1;
    checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", o_ready); end
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", o_data); end
    checks++; if (o_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", o_sel); end
    i_rst = 1'b0; i_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_sel;
    logic [3:0]  exp_rdy;
    i_valid = 4'b1111; i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_sel = 2'(c % 4);
      exp_rdy = 4'b0001 << exp_sel;
      #1;
      checks++; if (o_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c=%0d got %b exp %b", c, o_ready, exp_rdy); end
      step();
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rr_valid c=%0d got %b exp 1", c, o_valid); end
      checks++; if (o_sel !== exp_sel) begin errors++; $display("FAIL rr_sel c=%0d got %0d exp %0d", c, o_sel, exp_sel); end
      checks++; if (o_data !== 64'h10 + 64'(exp_sel)) begin errors++; $display("FAIL rr_data c=%0d got %h exp %h", c, o_data, 64'h10 + 64'(exp_sel)); end
    end
  endtask

  task automatic test_wrap();
    i_valid = 4'b1000; i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3 got %b exp 1000", o_ready); end
    step();
    checks++; if (o_sel !== 2'd3) begin errors++; $display("FAIL wrap_sel3 got %0d exp 3", o_sel); end
    i_valid = 4'b0001;
    #1;
    checks++; if (o_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b exp 0001", o_ready); end
    step();
    checks++; if (o_sel !== 2'd0) begin errors++; $display("FAIL wrap_sel0 got %0d exp 0", o_sel); end
    checks++; if (o_data !== 64'h10) begin errors++; $display("FAIL wrap_data0 got %h exp 10", o_data); end
  endtask

  task automatic test_backpressure();
    i_valid = 4'b0110; i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d got %b exp 0000", c, o_ready); end
      step();
      checks++; if (o_valid !== 1'b1 || o_data !== 64'h10 || o_sel !== 2'd0) begin
        errors++; $display("FAIL bp_hold c=%0d got v=%b d=%h s=%0d exp v=1 d=10 s=0", c, o_valid, o_data, o_sel);
      end
    end
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", o_ready); end
    step();
    checks++; if (o_sel !== 2'd1 || o_data !== 64'h11) begin errors++; $display("FAIL bp_release_beat got s=%0d d=%h exp s=1 d=11", o_sel, o_data); end
  endtask

  task automatic test_reset_midstream();
    i_data[2*DW +: DW] = 64'hAA;
    i_valid = 4'b0100; i_ready = 1'b1;
    step();
    checks++; if (o_data !== 64'hAA || o_sel !== 2'd2) begin errors++; $display("FAIL mid_load got d=%h s=%0d exp d=aa s=2", o_data, o_sel); end
    i_valid = 4'b0000; i_ready = 1'b0;
    step();
    i_rst = 1'b1; i_valid = 4'b1111; i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", o_ready); end
    step();
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_data !== 64'h0 || o_sel !== 2'd0) begin
      errors++; $display("FAIL mid_rst_state got v=%b d=%h s=%0d exp v=0 d=0 s=0", o_valid, o_data, o_sel);
    end
    set_data_default();
    i_valid = 4'b1010;
    #1;
    checks++; if (o_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got %b exp 0010", o_ready); end
    step();
    checks++; if (o_sel !== 2'd1) begin errors++; $display("FAIL mid_first_sel got %0d exp 1", o_sel); end
  endtask

  task automatic test_idle();
    i_valid = 4'b0000; i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (o_valid !== 1'b0 || o_data !== 64'h11 || o_sel !== 2'd1) begin
        errors++; $display("FAIL idle c=%0d got v=%b d=%h s=%0d exp v=0 d=11 s=1", c, o_valid, o_data, o_sel);
      end
    end
    i_valid = 4'b1111;
    #1;
    checks++; if (o_ready !== 4'b0100) begin errors++; $display("FAIL idle_ptr got %b exp 0100", o_ready); end
    step();
    checks++; if (o_sel !== 2'd2 || o_data !== 64'h12) begin errors++; $display("FAIL idle_next got s=%0d d=%h exp s=2 d=12", o_sel, o_data); end
    i_valid = 4'b0000;
    step();
  endtask

`ifdef CORE_RR_MUX_LOCK_EN
  task automatic test_lock();
    logic [3:0] lasts [3];
    lasts[0] = 4'b1011; lasts[1] = 4'b1011; lasts[2] = 4'b1111;
    i_rst = 1'b1; step(); i_rst = 1'b0;
    i_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      i_valid = (b == 0) ? 4'b0100 : 4'b1111;
      i_last  = lasts[b];
      #1;
      checks++; if (o_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready b=%0d got %b exp 0100", b, o_ready); end
      step();
      checks++; if (o_sel !== 2'd2) begin errors++; $display("FAIL lock_sel b=%0d got %0d exp 2", b, o_sel); end
      if (b == 0) begin
        i_valid = 4'b1011;
        #1;
        checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL lock_gap got %b exp 0000", o_ready); end
        step();
      end
    end
    i_valid = 4'b1111; i_last = 4'b1111;
    #1;
    checks++; if (o_ready !== 4'b1000) begin errors++; $display("FAIL lock_after_ready got %b exp 1000", o_ready); end
    step();
    checks++; if (o_sel !== 2'd3) begin errors++; $display("FAIL lock_after_sel got %0d exp 3", o_sel); end
    i_valid = 4'b0000;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    i_rst = 1'b1; i_valid = '0; i_ready = 1'b0; i_last = '1; i_data = '0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_midstream();
    test_idle();
`ifdef CORE_RR_MUX_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_rr_mux.md
CORE_RR_MUX -- requirements
Module: core_rr_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of each input channel and of o_data.
REQ-002 Parameter NUM_INPUTS, default 4, legal range 2..16, SHALL set the number of input channels.
REQ-003 Derived SEL_W = $clog2(NUM_INPUTS) SHALL be the width of o_sel.
REQ-004 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 i_valid  input  NUM_INPUTS  SHALL carry per-channel request valid, bit k = channel k.
REQ-007 i_data  input  NUM_INPUTS*DATA_WIDTH  SHALL carry channel k's payload at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 o_ready  output  NUM_INPUTS  SHALL be per-channel accept, at most one bit set per cycle.
REQ-009 o_valid  output  1  SHALL indicate o_data/o_sel hold a valid beat.
REQ-010 o_data  output  DATA_WIDTH  SHALL be the registered payload of the selected channel.
REQ-011 o_sel  output  SEL_W  SHALL be the index of the channel that produced o_data.
REQ-012 i_ready  input  1  SHALL be downstream accept; output beat transfers when o_valid && i_ready.

Function
REQ-013 load_en SHALL equal (!o_valid || i_ready); output register loads only when load_en = 1.
REQ-014 Arbitration SHALL be round-robin: search starts at rr_ptr, ascending, wrapping NUM_INPUTS-1 -> 0; first k with i_valid[k]=1 is granted.
REQ-015 o_ready[k] SHALL be 1 only when load_en = 1 and k is the granted channel; o_ready SHALL not depend on i_data.
REQ-016 On input transfer (i_valid[k] && o_ready[k]) the block SHALL load o_data <= channel k data, o_sel <= k, o_valid <= 1, rr_ptr <= (k+1) mod NUM_INPUTS, at the next edge (latency 1 cycle).
REQ-017 When load_en = 1 and no i_valid bit is set, o_valid SHALL go to 0 at the next edge; o_data and o_sel SHALL hold.
REQ-018 While o_valid && !i_ready, o_data, o_sel, o_valid SHALL remain stable and all o_ready bits SHALL be 0.
REQ-019 Simultaneous output transfer and new input transfer in one cycle SHALL be supported; sustained throughput 1 beat/cycle.
REQ-020 A single requesting channel SHALL be granted in the same cycle regardless of rr_ptr.
REQ-021 rr_ptr SHALL change only on an input transfer.
REQ-022 Combinational path i_ready -> o_ready is permitted; no path i_valid -> o_valid.

Reset
REQ-023 While i_rst = 1 at a rising edge: o_valid <= 0, o_data <= 0, o_sel <= 0, rr_ptr <= 0, lock state cleared.
REQ-024 o_ready SHALL be all-zero in any cycle where i_rst = 1.
REQ-025 Reset asserted mid-stream SHALL discard the held beat; first grant after reset SHALL search from channel 0.

Configuration
REQ-026 Macro CORE_RR_MUX_LOCK_EN defined: input port i_last (NUM_INPUTS bits) SHALL exist; a transfer from channel k with i_last[k] = 0 SHALL lock the grant to k; other channels SHALL get o_ready = 0 until k transfers with i_last[k] = 1, which releases the lock and advances rr_ptr to k+1.
REQ-027 While locked, rr_ptr SHALL not advance; a locked channel with i_valid = 0 SHALL keep the lock (no grant to others).
REQ-028 Macro undefined: no i_last port; every transfer is an independent single-beat arbitration per REQ-014..REQ-021.

Verification (NUM_INPUTS=4, DATA_WIDTH=64)
REQ-029 Reset then i_valid=4'b1111, i_ready=1, data k=0x10+k -> o_sel 0,1,2,3,0 on successive cycles, o_data 0x10,0x11,0x12,0x13,0x10, o_valid=1 from cycle 1.
REQ-030 After grant to ch3, i_valid=4'b0001 -> ch0 granted same cycle (wrap), o_sel=0 next cycle, rr_ptr=1.
REQ-031 o_valid=1, i_ready=0 for 5 cycles with i_valid=4'b0110 -> o_ready=0, o_data unchanged; i_ready=1 -> ch1 granted that cycle.
REQ-032 Beat held (o_data=0xAA), i_rst=1 one cycle -> o_valid=0, o_data=0, o_sel=0 next cycle; then i_valid=4'b1010 -> ch1 granted first.
REQ-033 LOCK_EN: ch2 sends 3 beats, i_last[2]=0,0,1 with i_valid=4'b1111 -> o_sel=2,2,2 then 3; o_ready[0,1,3]=0 throughout the burst.
REQ-034 No valids for 3 cycles with i_ready=1 after a beat -> o_valid=0, o_data/o_sel hold last values, rr_ptr unchanged.
